// File: rtl/gte_ucode_sequencer.sv
// GTE microcode sequencer: per-opcode start table plus a registered microcode store, streamed under valid/stall.
// Define GTE_UCODE_WRITE_EN to add an IDLE-only write port that overlays both storages.
module gte_ucode_sequencer #(
    parameter int PC_W    = 9,
    parameter int DEPTH   = 512,
    parameter int ENTRY_W = 96,
    parameter int OPC_W   = 6
) (
    input  logic               i_clk,
    input  logic               i_nRst,
    input  logic               i_start,
    input  logic [OPC_W-1:0]   i_instr,
    input  logic               i_stall,
`ifdef GTE_UCODE_WRITE_EN
    input  logic               i_wrEn,
    input  logic               i_wrSel,
    input  logic [PC_W-1:0]    i_wrAddr,
    input  logic [ENTRY_W-1:0] i_wrData,
`endif
    output logic               o_busy,
    output logic               o_valid,
    output logic [ENTRY_W-2:0] o_entry,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_last,
    output logic               o_done,
    output logic               o_illegal,
    output logic               o_overrun
);

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_DONE} state_t;

    // Built-in image: opcode -> first microcode address (0 = no microcode).
    function automatic logic [PC_W-1:0] table_rom(input logic [OPC_W-1:0] op);
        case (op)
            OPC_W'(6'h06): table_rom = PC_W'(9'h010);
            OPC_W'(6'h07): table_rom = PC_W'(9'h1FE);
            OPC_W'(6'h08): table_rom = PC_W'(9'h020);
            OPC_W'(6'h09): table_rom = PC_W'(9'h030);
            default:       table_rom = '0;
        endcase
    endfunction

    // Built-in image: payload tagged with its own address, lastInstr on program tails.
    function automatic logic [ENTRY_W-1:0] store_rom(input logic [PC_W-1:0] a);
        logic last;
        last = (a == PC_W'(9'h012)) || (a == PC_W'(9'h023)) || (a == PC_W'(9'h030));
        store_rom = {last, (ENTRY_W-1)'({7'h55, a, 16'hC0DE, a})};
    endfunction

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    rd_addr;
    logic [PC_W-1:0]    start_addr;
    logic [ENTRY_W-1:0] rd_data;
    logic [ENTRY_W-1:0] rd_q;
    logic               accept;
    logic               consume;
    logic               is_last;

    assign accept  = ((state == S_IDLE) || (state == S_DONE)) && i_start;
    assign consume = o_valid && !i_stall;
    assign is_last = rd_q[ENTRY_W-1];

`ifdef GTE_UCODE_WRITE_EN
    logic [PC_W-1:0]    tbl_ram [2**OPC_W];
    logic [2**OPC_W-1:0] tbl_wr;
    logic [ENTRY_W-1:0] st_ram [DEPTH];
    logic [DEPTH-1:0]   st_wr;
    logic               tbl_we;
    logic               st_we;

    assign tbl_we = i_wrEn && (state == S_IDLE) && i_wrSel;
    assign st_we  = i_wrEn && (state == S_IDLE) && !i_wrSel && (32'(i_wrAddr) < DEPTH);

    // A table write in the same cycle as i_start must be visible to the lookup.
    always_comb begin
        start_addr = table_rom(i_instr);
        if (tbl_we && (i_wrAddr[OPC_W-1:0] == i_instr))
            start_addr = i_wrData[PC_W-1:0];
        else if (tbl_wr[i_instr])
            start_addr = tbl_ram[i_instr];
    end

    assign rd_data = st_wr[rd_addr] ? st_ram[rd_addr] : store_rom(rd_addr);

    always_ff @(posedge i_clk) begin
        if (tbl_we) tbl_ram[i_wrAddr[OPC_W-1:0]] <= i_wrData[PC_W-1:0];
        if (st_we)  st_ram[i_wrAddr]             <= i_wrData;
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            tbl_wr <= '0;
            st_wr  <= '0;
        end else begin
            if (tbl_we) tbl_wr[i_wrAddr[OPC_W-1:0]] <= 1'b1;
            if (st_we)  st_wr[i_wrAddr]             <= 1'b1;
        end
    end
`else
    assign start_addr = table_rom(i_instr);
    assign rd_data    = store_rom(rd_addr);
`endif

    // Read address: new start on accept, pc+1 on a non-final consume, else re-read pc.
    always_comb begin
        rd_addr = pc;
        if (accept)
            rd_addr = start_addr;
        else if ((state == S_RUN) && consume && !is_last && (pc != LAST_PC))
            rd_addr = pc + PC_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state     <= S_IDLE;
            pc        <= '0;
            rd_q      <= '0;
            o_busy    <= 1'b0;
            o_valid   <= 1'b0;
            o_done    <= 1'b0;
            o_illegal <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            rd_q      <= rd_data;
            o_done    <= 1'b0;
            o_illegal <= 1'b0;
            o_overrun <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (i_start) begin
                        if (start_addr == '0) begin
                            state     <= S_DONE;
                            o_done    <= 1'b1;
                            o_illegal <= 1'b1;
                        end else begin
                            state  <= S_FETCH;
                            pc     <= start_addr;
                            o_busy <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    state   <= S_RUN;
                    o_valid <= 1'b1;
                end
                S_RUN: begin
                    if (consume) begin
                        if (is_last || (pc == LAST_PC)) begin
                            state     <= S_DONE;
                            o_busy    <= 1'b0;
                            o_valid   <= 1'b0;
                            o_done    <= 1'b1;
                            o_overrun <= !is_last;
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_entry = rd_q[ENTRY_W-2:0];
    assign o_pc    = pc;
    assign o_last  = o_valid && is_last;

endmodule

// File: tb/tb_gte_ucode_sequencer.sv
// Self-checking bench: each program's expected entry list is derived from a model image, then
// compared cycle by cycle under random stalls, ignored busy starts and back-to-back issue.
module tb_gte_ucode_sequencer;
    localparam int PC_W = 9, DEPTH = 512, ENTRY_W = 96, OPC_W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, start, stall;
    logic [OPC_W-1:0]   instr;
    logic               busy, valid, last, done, illegal, overrun;
    logic [ENTRY_W-2:0] entry;
    logic [PC_W-1:0]    pc;
`ifdef GTE_UCODE_WRITE_EN
    logic               wr_en, wr_sel;
    logic [PC_W-1:0]    wr_addr;
    logic [ENTRY_W-1:0] wr_data;
`endif

    gte_ucode_sequencer #(.PC_W(PC_W), .DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .OPC_W(OPC_W)) dut (
        .i_clk(clk), .i_nRst(rst_n), .i_start(start), .i_instr(instr), .i_stall(stall),
`ifdef GTE_UCODE_WRITE_EN
        .i_wrEn(wr_en), .i_wrSel(wr_sel), .i_wrAddr(wr_addr), .i_wrData(wr_data),
`endif
        .o_busy(busy), .o_valid(valid), .o_entry(entry), .o_pc(pc), .o_last(last),
        .o_done(done), .o_illegal(illegal), .o_overrun(overrun)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model image of both storages
    logic [PC_W-1:0]    m_tbl [2**OPC_W];
    logic [ENTRY_W-1:0] m_st  [DEPTH];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Precondition: start/instr already driven for the issuing cycle. Returns in the DONE cycle.
    task automatic run(input logic [OPC_W-1:0] opc, input int stall_pct, input logic [15:0] stall_mask,
                       input bit busy_start, input bit chain, input logic [OPC_W-1:0] next_opc,
                       input bit wr_in_run);
        logic [PC_W-1:0] q[$];
        logic [PC_W-1:0] a;
        bit ovr, st;
        int idx, c;
        ovr = 0;
        a = m_tbl[opc];
        if (a != '0) begin
            while (1) begin
                q.push_back(a);
                if (m_st[a][ENTRY_W-1]) break;
                if (int'(a) == DEPTH - 1) begin ovr = 1; break; end
                a = a + 1'b1;
            end
        end
        cyc();
        start = 1'b0;
        if (q.size() == 0) begin
            chk("illegal_done", done, 1);
            chk("illegal_flag", illegal, 1);
            chk("illegal_valid", valid, 0);
        end else begin
            chk("fetch_busy", busy, 1);
            chk("fetch_valid", valid, 0);
            chk("fetch_done", done, 0);
            c = 1;
            idx = 0;
            while (idx < q.size()) begin
                cyc();
                c++;
                start = 1'b0;
`ifdef GTE_UCODE_WRITE_EN
                wr_en = 1'b0;
`endif
                if (c > 200) begin
                    chk("run_timeout", 1, 0);
                    break;
                end
                chk("run_valid", valid, 1);
                chk("run_busy", busy, 1);
                chk("run_pc", pc, q[idx]);
                chk("run_entry", entry, m_st[q[idx]][ENTRY_W-2:0]);
                chk("run_last", last, m_st[q[idx]][ENTRY_W-1]);
                st = (c < 16 && stall_mask[c]) || (int'($urandom_range(0, 99)) < stall_pct);
                stall = st;
                if (busy_start && ($urandom_range(0, 2) == 0)) begin
                    start = 1'b1;
                    instr = OPC_W'($urandom);
                end
`ifdef GTE_UCODE_WRITE_EN
                if (wr_in_run && c == 2) begin
                    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = PC_W'(opc); wr_data = '0;
                end
`endif
                if (!st) idx++;
            end
            cyc();
            stall = 1'b0;
            start = 1'b0;
`ifdef GTE_UCODE_WRITE_EN
            wr_en = 1'b0;
`endif
            chk("end_done", done, 1);
            chk("end_overrun", overrun, ovr);
            chk("end_illegal", illegal, 0);
            chk("end_valid", valid, 0);
            chk("end_busy", busy, 0);
        end
        if (chain) begin
            start = 1'b1;
            instr = next_opc;
        end
    endtask

    task automatic issue(input logic [OPC_W-1:0] opc);
        cyc();
        start = 1'b1;
        instr = opc;
    endtask

    function automatic logic [OPC_W-1:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 6'h06;
            1: pick = 6'h07;
            2: pick = 6'h08;
            3: pick = 6'h09;
            4: pick = 6'h00;
            default: pick = OPC_W'($urandom);
        endcase
    endfunction

    initial begin
        logic [OPC_W-1:0] cur, nxt;
        bit pend, ch;
        for (int i = 0; i < 2**OPC_W; i++) m_tbl[i] = '0;
        m_tbl[6'h06] = 9'h010;
        m_tbl[6'h07] = 9'h1FE;
        m_tbl[6'h08] = 9'h020;
        m_tbl[6'h09] = 9'h030;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PC_W-1:0] ad;
            ad = PC_W'(i);
            m_st[i] = {(i == 'h12 || i == 'h23 || i == 'h30),
                       (ENTRY_W-1)'({7'h55, ad, 16'hC0DE, ad})};
        end

        rst_n = 1'b0; start = 1'b0; stall = 1'b0; instr = '0;
`ifdef GTE_UCODE_WRITE_EN
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
`endif
        cyc(); cyc();
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_done", done, 0);
        chk("rst_pc", pc, 0);
        chk("rst_entry", entry, 0);
        rst_n = 1'b1;

        // Basic, fixed stall in cycles 3-4, illegal, overrun
        issue(6'h06); run(6'h06, 0, 16'h0000, 0, 0, 0, 0);
        issue(6'h06); run(6'h06, 0, 16'h0018, 0, 0, 0, 0);
        issue(6'h00); run(6'h00, 0, 16'h0000, 0, 0, 0, 0);
        issue(6'h07); run(6'h07, 0, 16'h0000, 0, 0, 0, 0);
        // Starts during RUN ignored; start in DONE chains the next program
        issue(6'h08); run(6'h08, 0, 16'h0000, 1, 1, 6'h09, 0);
        run(6'h09, 0, 16'h0000, 0, 1, 6'h06, 0);
        run(6'h06, 0, 16'h0000, 0, 0, 0, 0);

        // Reset in cycle 3 of a running program
        issue(6'h08);
        cyc(); start = 1'b0;
        cyc(); cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_entry", entry, 0);
        chk("mid_rst_last", last, 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end
        issue(6'h08); run(6'h08, 0, 16'h0000, 0, 0, 0, 0);

`ifdef GTE_UCODE_WRITE_EN
        cyc();
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 9'h100;
        wr_data = {1'b1, (ENTRY_W-1)'(12'h5A5)};
        m_st[9'h100] = wr_data;
        cyc();
        wr_sel = 1'b1; wr_addr = 9'h02A; wr_data = (ENTRY_W)'(9'h100);
        m_tbl[6'h2A] = 9'h100;
        start = 1'b1; instr = 6'h2A;
        run(6'h2A, 0, 16'h0000, 0, 0, 0, 1);
        issue(6'h2A); run(6'h2A, 0, 16'h0000, 0, 0, 0, 0);
`endif

        // Randomized programs, stalls, busy starts and chaining
        pend = 0;
        cur = pick();
        for (int i = 0; i < 40; i++) begin
            if (!pend) issue(cur);
            nxt = pick();
            ch = (i != 39) && ($urandom_range(0, 1) == 1);
            run(cur, int'($urandom_range(0, 60)), 16'h0000, 1, ch, nxt, 0);
            pend = ch;
            cur = nxt;
        end
        cyc();
        chk("final_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
